hazard_ctrl: RTL

Pipeline hazard and stall controller for the MIPS III five-stage core. Compares source registers in ID/EX against destinations in EX/M/WB and produces per-stage stall and flush controls consumed by the IF/ID, ID/EX, EX/M and M/WB registers. It also selects forwarding sources and sequences the multi-cycle multiply/divide unit. On that unit's behalf it stalls HI/LO accesses until the result is written.

---
 rtl/hazard_pkg.sv | 54 +++++
 rtl/hazard_ctrl_muldiv_seq.sv | 83 ++++++++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the pipeline hazard
// controller.
//   fwd_sel_t       forwarding source select (none / M stage / WB stage)
//   muldiv_state_t  state of the multiply/divide sequencer
//   DP_*            bit positions inside the ID_DP_Hazards decode vector
//   reg_match()     destination-vs-source comparator
//   fwd_select()    forwarding priority (M is younger, so it beats WB)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_M    = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } muldiv_state_t;

    // ID_Rs/ID_Rt usage flags from the decoder, MSB first.
    localparam int DP_WANT_RS_ID = 7;
    localparam int DP_NEED_RS_ID = 6;
    localparam int DP_WANT_RT_ID = 5;
    localparam int DP_NEED_RT_ID = 4;
    localparam int DP_WANT_RS_EX = 3;
    localparam int DP_NEED_RS_EX = 2;
    localparam int DP_WANT_RT_EX = 1;
    localparam int DP_NEED_RT_EX = 0;

    localparam int MD_CNT_W = 6;

    // A stage produces the source value only if it writes a real register;
    // $0 is hard-wired to zero and is never a dependency.
    function automatic logic reg_match(input logic [4:0] dest,
                                       input logic [4:0] src,
                                       input logic       wr);
        return wr && (dest == src) && (dest != 5'd0);
    endfunction

    function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                            input logic [4:0] m_dest,
                                            input logic       m_wr,
                                            input logic [4:0] wb_dest,
                                            input logic       wb_wr);
        if (reg_match(m_dest, src, m_wr))
            return FWD_M;
        else if (reg_match(wb_dest, src, wb_wr))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// muldiv_seq: sequencer for the multi-cycle multiply/divide unit.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   start, is_div   EX holds a mult/div; is_div picks the divide latency
//   ex_stall        EX register is held this cycle (start not accepted)
//   exception       exception flush this cycle (start not accepted)
//   busy            unit running; HI/LO not yet valid
//   done            one-cycle pulse in the cycle HI/LO is written
//   dbg_state       current FSM state, for observation
//   dbg_cnt         current down-counter value, for observation
//
// Start handshake: a start is accepted on a rising edge where start=1,
// ex_stall=0, exception=0 and the FSM is idle. While busy the top level
// stalls any new start, so an accepted operation always runs to completion.
module muldiv_seq
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                is_div,
    input  logic                ex_stall,
    input  logic                exception,
    output logic                busy,
    output logic                done,
    output muldiv_state_t       dbg_state,
    output logic [MD_CNT_W-1:0] dbg_cnt
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);

    muldiv_state_t       state, state_nxt;
    logic [MD_CNT_W-1:0] cnt, cnt_nxt;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. The counter keeps running through pipeline stalls
    // because the arithmetic unit itself is never held.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MD_IDLE: begin
                if (start && !ex_stall && !exception) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0)
                    state_nxt = MD_IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state == MD_BUSY);
        done      = (state == MD_BUSY) && (cnt == '0);
        dbg_state = state;
        dbg_cnt   = cnt;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, stall chain, forwarding select and
// multiply/divide sequencing for the five-stage MIPS III pipeline.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   ID_Rs, ID_Rt, ID_DP_Hazards  ID sources and their need/want flags
//   EX_Rs, EX_Rt, EX_Need*ByEX   EX sources and need flags
//   *_RtRd, *_RegWrite           destination and write enable per stage
//   EX_MemRead, M_MemRead        stage holds a load
//   EX_MulDivStart, EX_IsDiv     EX holds a mult/div (and which kind)
//   EX_HiLoAccess                EX holds mfhi/mflo/mthi/mtlo
//   IMemBusy, DMemBusy           memory not ready
//   Exception                    flush request
//   *_Stall, *_Flush             per-stage register controls
//   *FwdSel                      forwarding select (00 none, 01 M, 10 WB)
//   MulDivBusy, MulDivDone       sequencer status
// Stall and forwarding outputs are purely combinational.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic [7:0] ID_DP_Hazards,
    input  logic [4:0] EX_Rs,
    input  logic [4:0] EX_Rt,
    input  logic       EX_NeedRsByEX,
    input  logic       EX_NeedRtByEX,
    input  logic [4:0] EX_RtRd,
    input  logic [4:0] M_RtRd,
    input  logic [4:0] WB_RtRd,
    input  logic       EX_RegWrite,
    input  logic       M_RegWrite,
    input  logic       WB_RegWrite,
    input  logic       EX_MemRead,
    input  logic       M_MemRead,
    input  logic       EX_MulDivStart,
    input  logic       EX_IsDiv,
    input  logic       EX_HiLoAccess,
    input  logic       IMemBusy,
    input  logic       DMemBusy,
    input  logic       Exception,
    output logic       IF_Stall,
    output logic       ID_Stall,
    output logic       EX_Stall,
    output logic       M_Stall,
    output logic       IF_Flush,
    output logic       ID_Flush,
    output logic [1:0] ID_RsFwdSel,
    output logic [1:0] ID_RtFwdSel,
    output logic [1:0] EX_RsFwdSel,
    output logic [1:0] EX_RtFwdSel,
    output logic       MulDivBusy,
    output logic       MulDivDone
);

    logic need_rs_id, need_rt_id, need_rs_ex, need_rt_ex;
    logic ex_m_rs, ex_m_rt, m_m_id_rs, m_m_id_rt, m_m_ex_rs, m_m_ex_rt;
    logic idh, exh, mds;

    muldiv_state_t       md_state;
    logic [MD_CNT_W-1:0] md_cnt;

    // The "want" flags only matter to the forwarding muxes in the datapath;
    // the stall decision is driven by the "need" flags alone.
    logic unused_want;
    assign unused_want = ^{ID_DP_Hazards[DP_WANT_RS_ID], ID_DP_Hazards[DP_WANT_RT_ID],
                           ID_DP_Hazards[DP_WANT_RS_EX], ID_DP_Hazards[DP_WANT_RT_EX],
                           md_state, md_cnt};

    assign need_rs_id = ID_DP_Hazards[DP_NEED_RS_ID];
    assign need_rt_id = ID_DP_Hazards[DP_NEED_RT_ID];
    assign need_rs_ex = ID_DP_Hazards[DP_NEED_RS_EX];
    assign need_rt_ex = ID_DP_Hazards[DP_NEED_RT_EX];

    // Comparators
    assign ex_m_rs   = reg_match(EX_RtRd, ID_Rs, EX_RegWrite);
    assign ex_m_rt   = reg_match(EX_RtRd, ID_Rt, EX_RegWrite);
    assign m_m_id_rs = reg_match(M_RtRd,  ID_Rs, M_RegWrite);
    assign m_m_id_rt = reg_match(M_RtRd,  ID_Rt, M_RegWrite);
    assign m_m_ex_rs = reg_match(M_RtRd,  EX_Rs, M_RegWrite);
    assign m_m_ex_rt = reg_match(M_RtRd,  EX_Rt, M_RegWrite);

    // ID hazard: an ID-resolved operand (branch compare) cannot be forwarded
    // from EX, nor from a load still in M; an EX-consumed operand cannot be
    // taken from a load still in EX (load-use).
    assign idh = (need_rs_id && ex_m_rs)
              || (need_rt_id && ex_m_rt)
              || (need_rs_id && M_MemRead && m_m_id_rs)
              || (need_rt_id && M_MemRead && m_m_id_rt)
              || (need_rs_ex && EX_MemRead && ex_m_rs)
              || (need_rt_ex && EX_MemRead && ex_m_rt);

    // EX hazard: EX needs a value a load in M has not produced yet.
    assign exh = (EX_NeedRsByEX && M_MemRead && m_m_ex_rs)
              || (EX_NeedRtByEX && M_MemRead && m_m_ex_rt);

    // HI/LO readers/writers and new mult/div wait while the unit runs,
    // including the done cycle.
    assign mds = MulDivBusy && (EX_HiLoAccess || EX_MulDivStart);

    // Stall chain: any stage holding forces all older stages to hold.
    assign M_Stall  = DMemBusy;
    assign EX_Stall = M_Stall || exh || mds;
    assign ID_Stall = EX_Stall || idh;
    assign IF_Stall = ID_Stall || IMemBusy;

    assign IF_Flush = Exception;
    assign ID_Flush = Exception;

    // Forwarding selects
    assign ID_RsFwdSel = fwd_select(ID_Rs, M_RtRd, M_RegWrite, WB_RtRd, WB_RegWrite);
    assign ID_RtFwdSel = fwd_select(ID_Rt, M_RtRd, M_RegWrite, WB_RtRd, WB_RegWrite);
    assign EX_RsFwdSel = fwd_select(EX_Rs, M_RtRd, M_RegWrite, WB_RtRd, WB_RegWrite);
    assign EX_RtFwdSel = fwd_select(EX_Rt, M_RtRd, M_RegWrite, WB_RtRd, WB_RegWrite);

    muldiv_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_muldiv_seq (
        .CLK       (CLK),
        .RST       (RST),
        .start     (EX_MulDivStart),
        .is_div    (EX_IsDiv),
        .ex_stall  (EX_Stall),
        .exception (Exception),
        .busy      (MulDivBusy),
        .done      (MulDivDone),
        .dbg_state (md_state),
        .dbg_cnt   (md_cnt)
    );

endmodule
